// File: rtl/stream_parity_unit.sv
// ============================================================================
// Module   : stream_parity_unit
// Purpose  : Framed-stream parity accumulator with valid/ready on both sides.
//            Returns one packet per frame: parity, column XOR, count, overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_parity_unit #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [WIDTH-1:0] out_col,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   col_q, col_d;
    logic               par_q, par_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               opar_q, opar_d;
    logic [WIDTH-1:0]   ocol_q, ocol_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               oerr_q, oerr_d;

    logic               w_accept;
    logic               w_first;
    logic [WIDTH-1:0]   w_col_n;
    logic               w_par_n;
    logic               w_mode_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic               w_err_n;

    assign in_ready  = !rst && (state_q != HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_first   = (state_q == IDLE);

    // Frame values as they stand after absorbing the current word
    assign w_col_n  = w_first ? in_data  : (col_q ^ in_data);
    assign w_par_n  = w_first ? ^in_data : (par_q ^ (^in_data));
    assign w_mode_n = w_first ? odd_mode : mode_q;
    assign w_cnt_n  = w_first ? C_CNT_ONE
                    : ((cnt_q == C_CNT_MAX) ? cnt_q : (cnt_q + C_CNT_ONE));
    assign w_err_n  = w_first ? 1'b0 : (err_q || (cnt_q == C_CNT_MAX));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        par_d   = par_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        opar_d  = opar_q;
        ocol_d  = ocol_q;
        ocnt_d  = ocnt_q;
        oerr_d  = oerr_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    col_d  = w_col_n;
                    par_d  = w_par_n;
                    mode_d = w_mode_n;
                    cnt_d  = w_cnt_n;
                    err_d  = w_err_n;
                    if (in_last) begin
                        state_d = HOLD;
                        opar_d  = w_par_n ^ w_mode_n;
                        ocol_d  = w_col_n;
                        ocnt_d  = w_cnt_n;
                        oerr_d  = w_err_n;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    opar_d  = 1'b0;
                    ocol_d  = '0;
                    ocnt_d  = '0;
                    oerr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            par_q   <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            opar_q  <= 1'b0;
            ocol_q  <= '0;
            ocnt_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            par_q   <= par_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            opar_q  <= opar_d;
            ocol_q  <= ocol_d;
            ocnt_q  <= ocnt_d;
            oerr_q  <= oerr_d;
        end
    end

    assign out_valid  = (state_q == HOLD);
    assign out_parity = opar_q;
    assign out_col    = ocol_q;
    assign out_count  = ocnt_q;
    assign out_err    = oerr_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_parity_unit.sv
// ============================================================================
// Module   : tb_stream_parity_unit
// Purpose  : Self-checking bench for stream_parity_unit (vectors + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_parity_unit;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [WIDTH-1:0] out_col;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    stream_parity_unit #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .odd_mode(odd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_parity(out_parity), .out_col(out_col),
        .out_count(out_count), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int               n;
        logic [3:0][7:0]  w;
        logic             mode;
        logic             exp_par;
        logic [7:0]       exp_col;
        int               exp_cnt;
        logic             exp_err;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] fq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [7:0] d, input logic last, input logic mode);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = mode;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = $urandom_range(0, 1);
        in_data  = 8'($urandom);
    endtask

    // Sends fq as one frame, optionally with idle gaps, mode applied on first word.
    task automatic send_frame(input logic mode, input bit gaps);
        for (int i = 0; i < fq.size(); i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) @(negedge clk);
            end
            send_word(fq[i], (i == fq.size() - 1), (i == 0) ? mode : 1'($urandom));
        end
    endtask

    task automatic check_result(input string tag, input logic p, input logic [7:0] c,
                                input int cnt, input logic e);
        check({tag, "_valid"},  32'(out_valid),  32'd1);
        check({tag, "_parity"}, 32'(out_parity), 32'(p));
        check({tag, "_col"},    32'(out_col),    32'(c));
        check({tag, "_count"},  32'(out_count),  32'(cnt));
        check({tag, "_err"},    32'(out_err),    32'(e));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_valid_low", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        odd_mode = 1'b0; out_ready = 1'b0;

        vecs[0] = '{n:3, w:{8'h00, 8'h07, 8'h03, 8'h01}, mode:1'b0,
                    exp_par:1'b0, exp_col:8'h05, exp_cnt:3, exp_err:1'b0};
        vecs[1] = '{n:3, w:{8'h00, 8'h07, 8'h03, 8'h01}, mode:1'b1,
                    exp_par:1'b1, exp_col:8'h05, exp_cnt:3, exp_err:1'b0};
        vecs[2] = '{n:1, w:{8'h00, 8'h00, 8'h00, 8'hFF}, mode:1'b0,
                    exp_par:1'b0, exp_col:8'hFF, exp_cnt:1, exp_err:1'b0};
        vecs[3] = '{n:2, w:{8'h00, 8'h00, 8'hF0, 8'h0F}, mode:1'b1,
                    exp_par:1'b1, exp_col:8'hFF, exp_cnt:2, exp_err:1'b0};
        vecs[4] = '{n:4, w:{8'h01, 8'h00, 8'h55, 8'hAA}, mode:1'b0,
                    exp_par:1'b1, exp_col:8'hFE, exp_cnt:4, exp_err:1'b0};
        vecs[5] = '{n:1, w:{8'h00, 8'h00, 8'h00, 8'h80}, mode:1'b1,
                    exp_par:1'b0, exp_col:8'h80, exp_cnt:1, exp_err:1'b0};

        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_fields", {out_parity, out_err, 6'd0, out_col, 11'd0, out_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table vectors: result must be visible one cycle after the last word
        for (int v = 0; v < 6; v++) begin
            fq.delete();
            for (int i = 0; i < vecs[v].n; i++) fq.push_back(vecs[v].w[i]);
            out_ready = 1'b1;
            send_frame(vecs[v].mode, 1'b0);
            check_result($sformatf("vec%0d", v), vecs[v].exp_par, vecs[v].exp_col,
                         vecs[v].exp_cnt, vecs[v].exp_err);
            drain();
        end

        // Overflow: 17 words of 0x01
        fq.delete();
        for (int i = 0; i < 17; i++) fq.push_back(8'h01);
        out_ready = 1'b1;
        send_frame(1'b0, 1'b0);
        check_result("ovf", 1'b1, 8'h01, 16, 1'b1);
        drain();

        // Exactly MAX_WORDS words: no overflow
        fq.delete();
        for (int i = 0; i < 16; i++) fq.push_back(8'h03);
        send_frame(1'b0, 1'b0);
        check_result("max_exact", 1'b0, 8'h00, 16, 1'b0);
        drain();

        // Back-pressure: result pending, source keeps offering a word
        fq.delete();
        fq.push_back(8'h01); fq.push_back(8'h03); fq.push_back(8'h07);
        out_ready = 1'b0;
        send_frame(1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
            check_result($sformatf("bp%0d", k), 1'b0, 8'h05, 3, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_in_ready", 32'(in_ready), 32'd1);
        check("bp_after_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // Reset mid-frame discards the partial frame
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_fields", {out_parity, out_err, 6'd0, out_col, 11'd0, out_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid_after", 32'(out_valid), 32'd0);
        send_word(8'h80, 1'b1, 1'b0);
        check_result("midrst_next", 1'b1, 8'h80, 1, 1'b0);
        drain();

        // Randomised frames against a counting reference
        for (int f = 0; f < 40; f++) begin
            int         n, ones, dly;
            logic [7:0] col;
            logic       mode;
            n    = $urandom_range(1, 20);
            mode = 1'($urandom);
            fq.delete();
            ones = 0;
            col  = 8'h00;
            for (int i = 0; i < n; i++) begin
                logic [7:0] w;
                w = 8'($urandom);
                fq.push_back(w);
                ones += $countones(w);
                col  ^= w;
            end
            out_ready = 1'($urandom);
            send_frame(mode, 1'b1);
            check_result($sformatf("rnd%0d", f), 1'((ones % 2) ^ int'(mode)), col,
                         (n > MAX_WORDS) ? MAX_WORDS : n, (n > MAX_WORDS));
            out_ready = 1'b0;
            dly = $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) @(negedge clk);
            check($sformatf("rnd%0d_held", f), 32'(out_col), 32'(col));
            drain();
            out_ready = 1'($urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
